// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encoding, device response codes
// and a small elaboration-time helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_INHIBIT  = 2'd1,
    S_TX       = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_t;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  // Larger of two unsigned values, used to size shared timers.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO for received PS/2 bytes.
// Ports: clk, rst (sync active-low), wr_en/wr_data push, rd_en pop,
// rd_data head byte, full/empty flags.
// A push on a full FIFO is accepted only when a pop happens the same cycle.
module ps2_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host link controller: arbitrates one PS/2 line between received scan
// codes and host commands, inhibits the clock before each command, launches
// ps2_tx and waits for ACK with resend/timeout retry.
// Ports: cmd_* command handshake and status pulses, key_* received-byte FIFO,
// rx_* to ps2_rx, tx_*/ps2c_oe to ps2_tx and the line driver.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned ACK_TIMEOUT    = 1_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       busy,
  output logic       key_valid,
  output logic [7:0] key_data,
  input  logic       key_ready,
  output logic       overflow,
  output logic       rx_en,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       ps2c_oe,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_done
);

  localparam int unsigned TMAX = max_u(INHIBIT_CYCLES, ACK_TIMEOUT);
  localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam int unsigned RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          cmd_done_q, cmd_done_d;
  logic          cmd_err_q, cmd_err_d;
  logic          tx_start_q, tx_start_d;
  logic          overflow_q, overflow_d;
  logic          cmd_ready_q, busy_q, rx_en_q, ps2c_oe_q;
  logic          push_c, pop_c, retry_c, fifo_full, fifo_empty;

  assign pop_c = key_ready && !fifo_empty;

  // Next-state, timer, retry and pulse decode.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    tx_byte_d  = tx_byte_q;
    cmd_done_d = 1'b0;
    cmd_err_d  = 1'b0;
    tx_start_d = 1'b0;
    push_c     = 1'b0;
    retry_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        push_c = rx_done;
        if (cmd_valid) begin
          tx_byte_d = cmd_data;
          retry_d   = '0;
          timer_d   = TW'(INHIBIT_CYCLES - 1);
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == '0) begin
          state_d    = S_TX;
          timer_d    = TW'(ACK_TIMEOUT - 1);
          tx_start_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_TX: begin
        if (tx_done) begin
          state_d = S_WAIT_ACK;
          timer_d = TW'(ACK_TIMEOUT - 1);
        end else if (timer_q == '0) begin
          retry_c = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_WAIT_ACK: begin
        // A received byte takes priority over a same-cycle timeout.
        if (rx_done) begin
          if (rx_data == PS2_ACK) begin
            cmd_done_d = 1'b1;
            state_d    = S_IDLE;
          end else if (rx_data == PS2_RESEND) begin
            retry_c = 1'b1;
          end else begin
            push_c = 1'b1;
            if (timer_q != '0) timer_d = timer_q - TW'(1);
          end
        end else if (timer_q == '0) begin
          retry_c = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Resend or timeout: re-inhibit and resend the same byte, or give up.
    if (retry_c) begin
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + RW'(1);
        timer_d = TW'(INHIBIT_CYCLES - 1);
        state_d = S_INHIBIT;
      end else begin
        cmd_err_d = 1'b1;
        state_d   = S_IDLE;
      end
    end
  end

  assign overflow_d = push_c && fifo_full && !pop_c;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      tx_byte_q   <= 8'h00;
      cmd_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      overflow_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rx_en_q     <= 1'b1;
      ps2c_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      tx_byte_q   <= tx_byte_d;
      cmd_done_q  <= cmd_done_d;
      cmd_err_q   <= cmd_err_d;
      tx_start_q  <= tx_start_d;
      overflow_q  <= overflow_d;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      rx_en_q     <= (state_d == S_IDLE) || (state_d == S_WAIT_ACK);
      ps2c_oe_q   <= (state_d == S_INHIBIT);
    end
  end

  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_c),
    .wr_data (rx_data),
    .rd_en   (pop_c),
    .rd_data (key_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign key_valid = !fifo_empty;
  assign cmd_ready = cmd_ready_q;
  assign cmd_done  = cmd_done_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign rx_en     = rx_en_q;
  assign ps2c_oe   = ps2c_oe_q;
  assign tx_start  = tx_start_q;
  assign tx_byte   = tx_byte_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl: table-driven FIFO vectors in idle plus
// hand-written command, resend, timeout and mid-command reset sequences.
module tb_ps2_host_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, cmd_done, cmd_err, busy;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_ready = 1'b0;
  logic       overflow, rx_en;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       ps2c_oe, tx_start;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b0;

  int total = 0;
  int bad   = 0;
  int n_tx = 0, n_done = 0, n_err = 0;

  always #5 clk = ~clk;

  ps2_host_ctrl #(
    .INHIBIT_CYCLES(10), .ACK_TIMEOUT(50), .MAX_RETRY(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .overflow(overflow), .rx_en(rx_en), .rx_done(rx_done), .rx_data(rx_data),
    .ps2c_oe(ps2c_oe), .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done)
  );

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_start === 1'b1) n_tx   <= n_tx + 1;
    if (cmd_done === 1'b1) n_done <= n_done + 1;
    if (cmd_err  === 1'b1) n_err  <= n_err + 1;
  end

  typedef struct {
    logic       rxd;
    logic [7:0] rdat;
    logic       pop;
    logic       kv;
    logic [7:0] kd;
    logic       ov;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic rxd, logic [7:0] rdat, logic pop,
                              logic kv, logic [7:0] kd, logic ov);
    vec_t v;
    v.rxd = rxd; v.rdat = rdat; v.pop = pop; v.kv = kv; v.kd = kd; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_data  = b;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic wait_tx_start(output bit ok);
    int n = 0;
    while (tx_start !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    ok = (tx_start === 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, tx0, done0, err0;

    // rx_done, rx_data, pop | key_valid, key_data, overflow
    vecs[0]  = mk(1, 8'h1C, 0, 1, 8'h1C, 0);
    vecs[1]  = mk(0, 8'h00, 1, 0, 8'h00, 0);
    vecs[2]  = mk(1, 8'h11, 0, 1, 8'h11, 0);
    vecs[3]  = mk(1, 8'h22, 0, 1, 8'h11, 0);
    vecs[4]  = mk(1, 8'h33, 0, 1, 8'h11, 0);
    vecs[5]  = mk(1, 8'h44, 0, 1, 8'h11, 0);
    vecs[6]  = mk(1, 8'h55, 0, 1, 8'h11, 1);
    vecs[7]  = mk(0, 8'h00, 0, 1, 8'h11, 0);
    vecs[8]  = mk(0, 8'h00, 1, 1, 8'h22, 0);
    vecs[9]  = mk(1, 8'h66, 1, 1, 8'h33, 0);
    vecs[10] = mk(1, 8'h77, 0, 1, 8'h33, 0);
    vecs[11] = mk(1, 8'h88, 1, 1, 8'h44, 0);
    vecs[12] = mk(0, 8'h00, 1, 1, 8'h66, 0);
    vecs[13] = mk(0, 8'h00, 1, 1, 8'h77, 0);
    vecs[14] = mk(0, 8'h00, 1, 1, 8'h88, 0);
    vecs[15] = mk(0, 8'h00, 1, 0, 8'h00, 0);
    vecs[16] = mk(0, 8'h00, 1, 0, 8'h00, 0);
    vecs[17] = mk(1, 8'hFA, 0, 1, 8'hFA, 0);
    vecs[18] = mk(0, 8'h00, 1, 0, 8'h00, 0);

    // Reset state
    repeat (3) step();
    chk("rst_rx_en", rx_en, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ps2c_oe", ps2c_oe, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_done_err_ovf", {cmd_done, cmd_err, overflow}, 0);
    rst = 1'b1;
    step();

    // Idle receive / FIFO vectors
    for (int i = 0; i < 19; i++) begin
      rx_done   = vecs[i].rxd;
      rx_data   = vecs[i].rdat;
      key_ready = vecs[i].pop;
      step();
      chk($sformatf("vec%0d_key_valid", i), key_valid, vecs[i].kv);
      if (vecs[i].kv) chk($sformatf("vec%0d_key_data", i), key_data, vecs[i].kd);
      chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].ov);
      chk($sformatf("vec%0d_cmd_ready", i), cmd_ready, 1);
    end
    rx_done = 1'b0;
    key_ready = 1'b0;
    step();

    // Command with ACK
    tx0 = n_tx; done0 = n_done; err0 = n_err;
    send_cmd(8'hED);
    chk("ack_oe_first", ps2c_oe, 1);
    chk("ack_cmd_ready_low", cmd_ready, 0);
    chk("ack_busy", busy, 1);
    chk("ack_rx_en_inhibit", rx_en, 0);
    n = 0;
    while (ps2c_oe === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("ack_inhibit_len", n, 10);
    chk("ack_tx_start", tx_start, 1);
    chk("ack_tx_byte", tx_byte, 8'hED);
    chk("ack_rx_en_tx", rx_en, 0);
    pulse_tx_done();
    chk("ack_tx_start_once", tx_start, 0);
    chk("ack_rx_en_wait", rx_en, 1);
    pulse_rx(8'hFA);
    chk("ack_cmd_done", cmd_done, 1);
    chk("ack_busy_low", busy, 0);
    chk("ack_cmd_ready_back", cmd_ready, 1);
    step();
    chk("ack_cmd_done_pulse", cmd_done, 0);
    chk("ack_not_pushed", key_valid, 0);
    chk("ack_counts", {8'(n_tx - tx0), 8'(n_done - done0), 8'(n_err - err0)}, {8'd1, 8'd1, 8'd0});

    // Resend twice then ACK; a stray byte during WAIT_ACK goes to the FIFO
    tx0 = n_tx; done0 = n_done; err0 = n_err;
    send_cmd(8'hF3);
    for (int a = 0; a < 3; a++) begin
      wait_tx_start(ok);
      chk($sformatf("rs_tx_start_seen%0d", a), ok, 1);
      chk($sformatf("rs_tx_byte%0d", a), tx_byte, 8'hF3);
      pulse_tx_done();
      if (a == 0) begin
        pulse_rx(8'h5A);
        chk("rs_stray_key_valid", key_valid, 1);
        chk("rs_stray_key_data", key_data, 8'h5A);
        chk("rs_stray_busy", busy, 1);
      end
      pulse_rx((a < 2) ? 8'hFE : 8'hFA);
    end
    step();
    chk("rs_counts", {8'(n_tx - tx0), 8'(n_done - done0), 8'(n_err - err0)}, {8'd3, 8'd1, 8'd0});
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    chk("rs_fifo_drained", key_valid, 0);

    // Timeout: no tx_done, no ACK
    tx0 = n_tx; done0 = n_done; err0 = n_err;
    send_cmd(8'hFF);
    n = 0;
    while (cmd_err !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    chk("to_cmd_err_seen", cmd_err, 1);
    chk("to_cmd_ready", cmd_ready, 1);
    step();
    chk("to_cmd_err_pulse", cmd_err, 0);
    step();
    chk("to_counts", {8'(n_tx - tx0), 8'(n_done - done0), 8'(n_err - err0)}, {8'd4, 8'd0, 8'd1});

    // Reset during S_INHIBIT discards the command and the FIFO
    pulse_rx(8'h42);
    chk("rr_key_valid", key_valid, 1);
    tx0 = n_tx; done0 = n_done; err0 = n_err;
    send_cmd(8'h12);
    repeat (3) step();
    chk("rr_oe_before", ps2c_oe, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rr_oe_low", ps2c_oe, 0);
    chk("rr_cmd_ready", cmd_ready, 1);
    chk("rr_busy", busy, 0);
    chk("rr_fifo_empty", key_valid, 0);
    repeat (30) step();
    chk("rr_oe_stays_low", ps2c_oe, 0);
    chk("rr_counts", {8'(n_tx - tx0), 8'(n_done - done0), 8'(n_err - err0)}, {8'd0, 8'd0, 8'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
